// File: rtl/game_pkg.sv
// game_pkg: definitions shared by the air-hockey game sequencer and the
// display stage.
//   game_state_t : state encoding driven onto the display stage.
//   winner_t     : winner encoding.
//   DEF_*        : default goal-mouth geometry in hc/vc units.
//   in_range     : inclusive unsigned window compare on coordinates.
package game_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned SCORE_W = 4;

    // Goal-mouth geometry (inclusive bounds, board coordinates)
    localparam int unsigned DEF_GOAL_YLB     = 246;
    localparam int unsigned DEF_GOAL_YUB     = 296;
    localparam int unsigned DEF_LEFT_GOAL_X  = 224;
    localparam int unsigned DEF_RIGHT_GOAL_X = 704;

    // The display stage decodes these exact values, so the encoding is fixed
    typedef enum logic [1:0] {
        ST_SPLASH = 2'd0,
        ST_PLAY   = 2'd1,
        ST_END    = 2'd2,
        ST_SERVE  = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2
    } winner_t;

    function automatic logic in_range(input logic [COORD_W-1:0] v,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/game_if.sv
// game_if: bundle between the game sequencer and the rest of the system.
//   btn_start      : raw start push-button
//   puck_x, puck_y : puck centre from the physics stage
//   state, rst     : sequencer state and paddle/puck home hold
//   score1/2       : player scores
//   goal1/2        : one-cycle goal pulses
//   winner         : winning player
// master = the sequencer, slave = its environment.
interface game_if;
    import game_pkg::*;

    logic                     btn_start;
    logic [COORD_W-1:0]       puck_x;
    logic [COORD_W-1:0]       puck_y;
    game_state_t              state;
    logic                     rst;
    logic [SCORE_W-1:0]       score1;
    logic [SCORE_W-1:0]       score2;
    logic                     goal1;
    logic                     goal2;
    winner_t                  winner;

    modport master (
        input  btn_start, puck_x, puck_y,
        output state, rst, score1, score2, goal1, goal2, winner
    );

    modport slave (
        output btn_start, puck_x, puck_y,
        input  state, rst, score1, score2, goal1, goal2, winner
    );

endinterface

// File: rtl/start_debounce.sv
// start_debounce: synchronizes and debounces the start button.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset (already release-synchronized)
//   btn     : raw asynchronous push-button
//   start_p : one-cycle pulse on an accepted 0->1 transition
module start_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic start_p
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync;
    logic             sync_q;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // sync_q holds the previous synchronized sample so any change restarts
    // the stability count; the count only runs while the synchronized level
    // differs from the accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            sync_q  <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            start_p <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            sync_q  <= sync[1];
            start_p <= 1'b0;
            if (sync[1] != sync_q) begin
                cnt <= '0;
            end else if (sync[1] != level) begin
                if (cnt == CNT_MAX) begin
                    level   <= sync[1];
                    cnt     <= '0;
                    start_p <= sync[1];
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: air-hockey game sequencer (splash / serve / play / end).
//   clk   : system clock shared with the display stage
//   clr_n : asynchronous active-low reset; release is synchronized here
//   gif   : game_if master - button and puck in; state, rst, scores,
//           goal pulses and winner out (all registered)
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned GOAL_YLB     = DEF_GOAL_YLB,
    parameter int unsigned GOAL_YUB     = DEF_GOAL_YUB,
    parameter int unsigned LEFT_GOAL_X  = DEF_LEFT_GOAL_X,
    parameter int unsigned RIGHT_GOAL_X = DEF_RIGHT_GOAL_X,
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned DEB_CYCLES   = 1000000,
    parameter int unsigned SERVE_CYCLES = 50000000
) (
    input  logic  clk,
    input  logic  clr_n,
    game_if.master gif
);

    localparam int unsigned SERVE_W = $clog2(SERVE_CYCLES + 1);
    localparam logic [SERVE_W-1:0] SERVE_LOAD = SERVE_W'(SERVE_CYCLES - 1);
    localparam logic [COORD_W-1:0] Y_LO  = COORD_W'(GOAL_YLB);
    localparam logic [COORD_W-1:0] Y_HI  = COORD_W'(GOAL_YUB);
    localparam logic [COORD_W-1:0] X_L   = COORD_W'(LEFT_GOAL_X);
    localparam logic [COORD_W-1:0] X_R   = COORD_W'(RIGHT_GOAL_X);
    localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);

    logic [1:0]         rst_sync;
    logic               rst_n;
    logic               start_p;
    logic [COORD_W-1:0] px, py;
    logic               zone_l, zone_r, goal_l, goal_r;
    logic               armed;
    game_state_t        st;
    logic               rst_q;
    logic [SCORE_W-1:0] score1, score2, score1_inc, score2_inc;
    logic               goal1_q, goal2_q;
    winner_t            winner_q;
    logic [SERVE_W-1:0] serve_cnt;

    // Assertion of clr_n clears everything at once; release ripples through
    // two flops so every register leaves reset on a clean clock edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    start_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_start_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (gif.btn_start),
        .start_p (start_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px <= '0;
            py <= '0;
        end else begin
            px <= gif.puck_x;
            py <= gif.puck_y;
        end
    end

    assign zone_l     = in_range(py, Y_LO, Y_HI) && (px <= X_L);
    assign zone_r     = in_range(py, Y_LO, Y_HI) && (px >= X_R);
    assign goal_l     = (st == ST_PLAY) && armed && zone_l;
    assign goal_r     = (st == ST_PLAY) && armed && zone_r;
    assign score1_inc = score1 + SCORE_W'(1);
    assign score2_inc = score2 + SCORE_W'(1);

    // The puck must leave both goal zones before another goal can count,
    // so a puck resting in the mouth through a serve scores only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (goal_l || goal_r) begin
            armed <= 1'b0;
        end else if (!zone_l && !zone_r) begin
            armed <= 1'b1;
        end
    end

    // Game flow with scores and all outputs registered. serve_cnt is loaded
    // with SERVE_CYCLES-1 so PLAY starts exactly SERVE_CYCLES edges after
    // the SERVE entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_SPLASH;
            rst_q     <= 1'b1;
            score1    <= '0;
            score2    <= '0;
            goal1_q   <= 1'b0;
            goal2_q   <= 1'b0;
            winner_q  <= WIN_NONE;
            serve_cnt <= '0;
        end else begin
            goal1_q <= 1'b0;
            goal2_q <= 1'b0;
            case (st)
                ST_SPLASH: begin
                    if (start_p) begin
                        score1    <= '0;
                        score2    <= '0;
                        winner_q  <= WIN_NONE;
                        serve_cnt <= SERVE_LOAD;
                        st        <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (serve_cnt == '0) begin
                        st    <= ST_PLAY;
                        rst_q <= 1'b0;
                    end else begin
                        serve_cnt <= serve_cnt - SERVE_W'(1);
                    end
                end
                ST_PLAY: begin
                    if (goal_r) begin
                        score1  <= score1_inc;
                        goal1_q <= 1'b1;
                        rst_q   <= 1'b1;
                        if (score1_inc == WIN) begin
                            winner_q <= WIN_P1;
                            st       <= ST_END;
                        end else begin
                            serve_cnt <= SERVE_LOAD;
                            st        <= ST_SERVE;
                        end
                    end else if (goal_l) begin
                        score2  <= score2_inc;
                        goal2_q <= 1'b1;
                        rst_q   <= 1'b1;
                        if (score2_inc == WIN) begin
                            winner_q <= WIN_P2;
                            st       <= ST_END;
                        end else begin
                            serve_cnt <= SERVE_LOAD;
                            st        <= ST_SERVE;
                        end
                    end
                end
                ST_END: begin
                    if (start_p) begin
                        st <= ST_SPLASH;
                    end
                end
                default: st <= ST_SPLASH;
            endcase
        end
    end

    assign gif.state  = st;
    assign gif.rst    = rst_q;
    assign gif.score1 = score1;
    assign gif.score2 = score2;
    assign gif.goal1  = goal1_q;
    assign gif.goal2  = goal2_q;
    assign gif.winner = winner_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: self-checking bench for game_ctrl with DEB_CYCLES=4,
// SERVE_CYCLES=16, WIN_SCORE=3. Directed sequences and a vector table
// cover reset, debounce, serve timing, goal boundaries and the win flow;
// randomized puck traffic is checked against a cycle-level game model.
module tb_game_ctrl;
    import game_pkg::*;

    localparam int DEB   = 4;
    localparam int SERVE = 16;
    localparam int WIN   = 3;
    localparam int CX    = 464;
    localparam int CY    = 271;
    localparam int S_SPLASH = 0;
    localparam int S_PLAY   = 1;
    localparam int S_END    = 2;
    localparam int S_SERVE  = 3;

    logic clk = 1'b0;
    logic clr_n = 1'b0;

    game_if gif();

    game_ctrl #(
        .WIN_SCORE    (WIN),
        .DEB_CYCLES   (DEB),
        .SERVE_CYCLES (SERVE)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .gif   (gif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int g1;
        int g2;
    } vec_t;

    vec_t vecs[8];
    int   bx[8] = '{224, 225, 703, 704, 0, 1023, 224, 704};
    int   by[8] = '{246, 296, 245, 297, 271, 271, 296, 246};

    int checks = 0;
    int failures = 0;
    int es1 = 0;
    int es2 = 0;

    // Reference game model state
    int m_state, m_s1, m_s2, m_win, m_armed, m_px, m_py, m_left, e_g1, e_g2;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic setPuck(input int x, input int y);
        gif.puck_x = 10'(x);
        gif.puck_y = 10'(y);
    endtask

    task automatic waitState(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (int'(gif.state) != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, int'(gif.state), target);
    endtask

    task automatic pressToState(input int target, input string name);
        bit seen;
        seen = 1'b0;
        gif.btn_start = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 9) gif.btn_start = 1'b0;
            if (int'(gif.state) == target) seen = 1'b1;
        end
        gif.btn_start = 1'b0;
        checkOutput(name, int'(seen), 1);
    endtask

    // Press start from SPLASH and time the serve hold up to PLAY
    task automatic startGame(input string name);
        int   t0;
        int   t1;
        logic rst_before;
        logic rst_at;
        t0 = -1;
        t1 = -1;
        rst_before = 1'b0;
        rst_at = 1'b1;
        setPuck(CX, CY);
        gif.btn_start = 1'b1;
        for (int i = 0; i < 60 && t1 < 0; i++) begin
            @(negedge clk);
            if (i == 9) gif.btn_start = 1'b0;
            if (t0 < 0 && int'(gif.state) == S_SERVE) begin
                t0 = i;
                checkOutput({name, "_serve_score1"}, int'(gif.score1), 0);
                checkOutput({name, "_serve_score2"}, int'(gif.score2), 0);
                checkOutput({name, "_serve_winner"}, int'(gif.winner), 0);
            end else if (t0 >= 0 && int'(gif.state) == S_SERVE) begin
                rst_before = gif.rst;
            end else if (t0 >= 0 && int'(gif.state) == S_PLAY) begin
                t1 = i;
                rst_at = gif.rst;
            end
        end
        gif.btn_start = 1'b0;
        checkOutput({name, "_start_latency_ok"}, int'(t0 >= 2 + DEB), 1);
        checkOutput({name, "_serve_len"}, t1 - t0, SERVE);
        checkOutput({name, "_rst_in_serve"}, int'(rst_before), 1);
        checkOutput({name, "_rst_in_play"}, int'(rst_at), 0);
        es1 = 0;
        es2 = 0;
    endtask

    // Apply one puck position in armed PLAY and check the goal timing
    task automatic applyStimulus(input int x, input int y, input int g1, input int g2,
                                 input string name);
        int n1, n2, exp_state, exp_win;
        n1 = es1 + g1;
        n2 = es2 + g2;
        if (g1 != 0 || g2 != 0) exp_state = (n1 == WIN || n2 == WIN) ? S_END : S_SERVE;
        else exp_state = S_PLAY;
        exp_win = (n1 == WIN) ? 1 : ((n2 == WIN) ? 2 : 0);
        setPuck(x, y);
        @(negedge clk);
        checkOutput({name, "_sample_goal1"}, int'(gif.goal1), 0);
        checkOutput({name, "_sample_goal2"}, int'(gif.goal2), 0);
        checkOutput({name, "_sample_state"}, int'(gif.state), S_PLAY);
        @(negedge clk);
        checkOutput({name, "_goal1"}, int'(gif.goal1), g1);
        checkOutput({name, "_goal2"}, int'(gif.goal2), g2);
        checkOutput({name, "_score1"}, int'(gif.score1), n1);
        checkOutput({name, "_score2"}, int'(gif.score2), n2);
        checkOutput({name, "_state"}, int'(gif.state), exp_state);
        checkOutput({name, "_rst"}, int'(gif.rst), int'(exp_state != S_PLAY));
        checkOutput({name, "_winner"}, int'(gif.winner), exp_win);
        @(negedge clk);
        checkOutput({name, "_goal1_drop"}, int'(gif.goal1), 0);
        checkOutput({name, "_goal2_drop"}, int'(gif.goal2), 0);
        checkOutput({name, "_score1_hold"}, int'(gif.score1), n1);
        es1 = n1;
        es2 = n2;
    endtask

    // One clock edge of the game rules, with (x,y) the puck seen at that edge
    function automatic void modelStep(input int x, input int y);
        bit in_mouth, zl, zr, goal;
        in_mouth = (m_py >= 246) && (m_py <= 296);
        zl = in_mouth && (m_px <= 224);
        zr = in_mouth && (m_px >= 704);
        goal = 1'b0;
        e_g1 = 0;
        e_g2 = 0;
        if (m_state == S_SERVE) begin
            m_left--;
            if (m_left == 0) m_state = S_PLAY;
        end else if (m_state == S_PLAY && m_armed != 0 && (zl || zr)) begin
            goal = 1'b1;
            if (zr) begin
                m_s1++;
                e_g1 = 1;
            end else begin
                m_s2++;
                e_g2 = 1;
            end
            if (m_s1 == WIN) begin
                m_win = 1;
                m_state = S_END;
            end else if (m_s2 == WIN) begin
                m_win = 2;
                m_state = S_END;
            end else begin
                m_state = S_SERVE;
                m_left = SERVE;
            end
        end
        if (goal) m_armed = 0;
        else if (!zl && !zr) m_armed = 1;
        m_px = x;
        m_py = y;
    endfunction

    task automatic runRandomGame(input int g);
        int x, y, hold, after_end;
        string p;
        x = CX;
        y = CY;
        hold = 0;
        after_end = 0;
        p = $sformatf("rand%0d", g);
        m_state = S_PLAY;
        m_s1 = 0;
        m_s2 = 0;
        m_win = 0;
        m_armed = 1;
        m_px = CX;
        m_py = CY;
        m_left = 0;
        for (int c = 0; c < 400 && after_end < 8; c++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 5))
                    0: begin x = int'($urandom_range(300, 650)); y = int'($urandom_range(0, 1023)); end
                    1: begin x = int'($urandom_range(704, 1023)); y = int'($urandom_range(246, 296)); end
                    2: begin x = int'($urandom_range(0, 224)); y = int'($urandom_range(246, 296)); end
                    3: begin
                        int k;
                        k = int'($urandom_range(0, 7));
                        x = bx[k];
                        y = by[k];
                    end
                    4: begin x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023)); end
                    default: begin
                        x = ($urandom_range(0, 1) == 0) ? 100 : 800;
                        y = ($urandom_range(0, 1) == 0) ? 245 : 297;
                    end
                endcase
                hold = int'($urandom_range(1, 5));
            end
            hold--;
            setPuck(x, y);
            @(posedge clk);
            modelStep(x, y);
            @(negedge clk);
            checkOutput({p, "_state"}, int'(gif.state), m_state);
            checkOutput({p, "_rst"}, int'(gif.rst), int'(m_state != S_PLAY));
            checkOutput({p, "_score1"}, int'(gif.score1), m_s1);
            checkOutput({p, "_score2"}, int'(gif.score2), m_s2);
            checkOutput({p, "_goal1"}, int'(gif.goal1), e_g1);
            checkOutput({p, "_goal2"}, int'(gif.goal2), e_g2);
            checkOutput({p, "_winner"}, int'(gif.winner), m_win);
            if (m_state == S_END) after_end++;
        end
        setPuck(CX, CY);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{224, 296, 0, 1};
        vecs[1] = '{224, 297, 0, 0};
        vecs[2] = '{225, 271, 0, 0};
        vecs[3] = '{0, 246, 0, 1};
        vecs[4] = '{703, 271, 0, 0};
        vecs[5] = '{464, 245, 0, 0};
        vecs[6] = '{1023, 297, 0, 0};
        vecs[7] = '{500, 296, 0, 0};

        // Reset with the puck at centre
        gif.btn_start = 1'b0;
        setPuck(CX, CY);
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", int'(gif.state), S_SPLASH);
        checkOutput("reset_rst", int'(gif.rst), 1);
        checkOutput("reset_score1", int'(gif.score1), 0);
        checkOutput("reset_score2", int'(gif.score2), 0);
        checkOutput("reset_goal1", int'(gif.goal1), 0);
        checkOutput("reset_goal2", int'(gif.goal2), 0);
        checkOutput("reset_winner", int'(gif.winner), 0);
        clr_n = 1'b1;
        repeat (3) @(negedge clk);

        // Bouncing button must never start the game
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 40; i++) begin
                if (i % 2 == 0) gif.btn_start = ~gif.btn_start;
                @(negedge clk);
                if (int'(gif.state) != S_SPLASH) bad++;
            end
            gif.btn_start = 1'b0;
            repeat (10) @(negedge clk);
            checkOutput("bounce_non_splash_cycles", bad, 0);
            checkOutput("bounce_state", int'(gif.state), S_SPLASH);
        end

        startGame("start1");

        // Right goal, then puck lingers in the zone through the serve
        applyStimulus(710, 270, 1, 0, "right_goal");
        waitState(S_PLAY, 40, "right_goal_back_to_play");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("linger_goal1", int'(gif.goal1), 0);
            checkOutput("linger_score1", int'(gif.score1), 1);
            checkOutput("linger_state", int'(gif.state), S_PLAY);
        end
        setPuck(CX, CY);
        repeat (2) @(negedge clk);
        applyStimulus(710, 270, 1, 0, "right_goal_rearmed");
        setPuck(CX, CY);
        waitState(S_PLAY, 40, "rearmed_back_to_play");

        // Left goal and mouth boundary vectors
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].x, vecs[v].y, vecs[v].g1, vecs[v].g2,
                          $sformatf("vec%0d_%0d_%0d", v, vecs[v].x, vecs[v].y));
            setPuck(CX, CY);
            if (vecs[v].g1 != 0 || vecs[v].g2 != 0) waitState(S_PLAY, 40, $sformatf("vec%0d_back_to_play", v));
            else repeat (2) @(negedge clk);
        end

        // Winning goal on the inclusive right/top corner of the mouth
        applyStimulus(704, 246, 1, 0, "win_goal");
        for (int i = 0; i < 6; i++) begin
            setPuck((i < 3) ? 0 : 710, (i < 3) ? 271 : 270);
            @(negedge clk);
            checkOutput("end_state", int'(gif.state), S_END);
            checkOutput("end_rst", int'(gif.rst), 1);
            checkOutput("end_score1", int'(gif.score1), 3);
            checkOutput("end_score2", int'(gif.score2), 2);
            checkOutput("end_goal1", int'(gif.goal1), 0);
            checkOutput("end_goal2", int'(gif.goal2), 0);
            checkOutput("end_winner", int'(gif.winner), 1);
        end
        setPuck(CX, CY);
        pressToState(S_SPLASH, "end_to_splash");
        checkOutput("splash_score1_held", int'(gif.score1), 3);
        checkOutput("splash_score2_held", int'(gif.score2), 2);
        checkOutput("splash_winner_held", int'(gif.winner), 1);
        checkOutput("splash_rst", int'(gif.rst), 1);
        startGame("restart");

        // Randomized games against the reference model
        for (int g = 0; g < 3; g++) begin
            runRandomGame(g);
            if (m_state == S_END) begin
                pressToState(S_SPLASH, $sformatf("rand%0d_to_splash", g));
            end else begin
                clr_n = 1'b0;
                @(negedge clk);
                clr_n = 1'b1;
                repeat (3) @(negedge clk);
            end
            startGame($sformatf("rand%0d_restart", g));
        end

        // Mid-game reset during SERVE with score2=2
        applyStimulus(100, 250, 0, 1, "p2_goal_a");
        setPuck(CX, CY);
        waitState(S_PLAY, 40, "p2_goal_a_back_to_play");
        applyStimulus(100, 250, 0, 1, "p2_goal_b");
        setPuck(CX, CY);
        repeat (3) @(negedge clk);
        checkOutput("midreset_pre_state", int'(gif.state), S_SERVE);
        checkOutput("midreset_pre_score2", int'(gif.score2), 2);
        clr_n = 1'b0;
        #1;
        checkOutput("midreset_state", int'(gif.state), S_SPLASH);
        checkOutput("midreset_score2", int'(gif.score2), 0);
        checkOutput("midreset_rst", int'(gif.rst), 1);
        checkOutput("midreset_winner", int'(gif.winner), 0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("after_release_state", int'(gif.state), S_SPLASH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
